hash_table_arbiter: RTL and testbench
=====================================

Name: hash_table_arbiter

Overview:
Shares one hash_table instance among NUM_REQ requesters (order-entry, cancel, market-data paths). Round-robin arbitration with a valid/ready request handshake per requester. Sequences the table's op/state protocol: holds op/key/value stable from the table's IDLE sample through DONE, then returns success/value to the granted requester. Sits directly in front of hash_table; table outputs connect straight in.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
KEY_WIDTH, 32, key width; must match hash_table
VALUE_WIDTH, 64, value width; must match hash_table
REQ_IDX_WIDTH, $clog2(NUM_REQ), requester index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot grant/accept, combinational
req_op  in  2*NUM_REQ  per-requester op (NOOP=0, INSERT=1, LOOKUP=2, ERASE=3), requester i at [2i+:2]
req_key  in  KEY_WIDTH*NUM_REQ  per-requester key
req_value  in  VALUE_WIDTH*NUM_REQ  per-requester insert value
rsp_valid  out  NUM_REQ  one-hot, 1-cycle response strobe
rsp_success  out  1  table success flag for the response
rsp_value  out  VALUE_WIDTH  table value_out for the response
ht_op  out  2  to hash_table op
ht_key  out  KEY_WIDTH  to hash_table key
ht_value_in  out  VALUE_WIDTH  to hash_table value_in
ht_value_out  in  VALUE_WIDTH  from hash_table value_out
ht_success  in  1  from hash_table success
ht_state  in  2  from hash_table state (IDLE=0, SEARCHING=1, INSERTING=2, DONE=3)

Behaviour:
- Clock clk; reset rst is synchronous, active-high. Reset: FSM=ARB, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_success=0, rsp_value=0, ht_op=NOOP, ht_key=0, ht_value_in=0.
- States: ARB, ISSUE, WAIT, RESP.
- ARB: ht_op=NOOP. If any req_valid, winner = first valid index searching rr_ptr, rr_ptr+1, ... with wrap mod NUM_REQ. Assert req_ready[winner] this cycle (transfer = valid&&ready). Latch op/key/value and winner id; rr_ptr <= winner+1 (wrap to 0 past NUM_REQ-1). Go to ISSUE, or to RESP directly if latched op==NOOP (response success=0, value=0, table untouched). No valid: stay.
- ISSUE: drive ht_op/ht_key/ht_value_in from the latched registers. When ht_state==IDLE, the table samples op on this edge. Go to WAIT. Otherwise (table in DONE from NOOP cycling) stay; wait is at most 1 cycle.
- WAIT: hold ht_op/ht_key/ht_value_in unchanged. When ht_state==DONE, register ht_success/ht_value_out and go to RESP. No fixed bound; table latency depends on chain length.
- RESP: ht_op=NOOP. rsp_valid[id]=1 for exactly one cycle with the captured success/value. Next state is ARB.
- rsp_success/rsp_value are 0 whenever rsp_valid==0. Requesters have no response backpressure.
- req_ready is never asserted outside ARB. At most one request is outstanding to the table.
- A requester whose request is not granted holds it. No starvation: worst-case wait is NUM_REQ-1 transactions.
- Reset mid-operation: FSM aborts to ARB and any in-flight response is dropped. rst is shared with hash_table.

Optional Feature:
HT_ARB_STATS_EN: when defined, adds ports stat_clr (in, 1), stat_ops (out, 32), stat_hits (out, 32).
- stat_ops counts completed table transactions (RESP entries with op!=NOOP).
- stat_hits counts those with success=1.
- Both saturate at 32'hFFFF_FFFF. They reset to 0 on rst and clear on stat_clr; stat_clr takes priority over a same-cycle increment.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package hash_table_pkg: state constants IDLE/SEARCHING/INSERTING/DONE, op constants NOOP/INSERT/LOOKUP/ERASE, NULL pointer constant. hash_table itself is updated to import the package.
- One sub-module, rr_arbiter: combinational winner select from req_valid and rr_ptr, producing one-hot grant and index.

Test Plan:
- Single requester 0 INSERT key=0x10 value=0xAA on an empty table -> one req_ready pulse; rsp_valid=4'b0001, success=1, value=0xAA. A following LOOKUP 0x10 -> success=1, value=0xAA.
- Requesters 0..3 all valid with LOOKUP, starting from rr_ptr=0 -> grants in order 0,1,2,3. Then with only 1 and 3 still valid -> grants 1 then 3, alternating.
- ERASE key=0x10 -> success=1, value=0xAA. Repeat ERASE -> success=0, value=0. LOOKUP 0x10 -> success=0.
- Requester 2 sends NOOP -> rsp_valid[2] within 2 cycles, success=0; ht_op never leaves NOOP.
- rst asserted while in WAIT during an INSERT -> next cycle all outputs are at reset values and no rsp_valid is emitted. A new request afterwards completes normally.
- HT_ARB_STATS_EN: 3 hits and 2 misses -> stat_ops=5, stat_hits=3. stat_clr asserted in the same cycle as a completion -> both counters 0.

Source files
------------

// File: rtl/hash_table_pkg.sv
// Shared constants for hash_table and its front-end arbiter: table state and
// op encodings, the null chain pointer, and the arbiter FSM state type.
package hash_table_pkg;

    localparam logic [1:0] HT_IDLE      = 2'd0;
    localparam logic [1:0] HT_SEARCHING = 2'd1;
    localparam logic [1:0] HT_INSERTING = 2'd2;
    localparam logic [1:0] HT_DONE      = 2'd3;

    localparam logic [1:0] OP_NOOP   = 2'd0;
    localparam logic [1:0] OP_INSERT = 2'd1;
    localparam logic [1:0] OP_LOOKUP = 2'd2;
    localparam logic [1:0] OP_ERASE  = 2'd3;

    localparam logic [15:0] NULL_PTR = 16'hFFFF;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/hash_table_arbiter_rr_arbiter.sv
// Combinational round-robin select: first valid requester at or after rr_ptr,
// wrapping modulo NUM_REQ, as both a one-hot grant and an index.
module rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [IDX_WIDTH-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]   grant,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic                 grant_any
);

    localparam int SW = IDX_WIDTH + 1;

    logic [SW-1:0]        sum;
    logic [IDX_WIDTH-1:0] cand;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sum = {1'b0, rr_ptr} + SW'(off);
            if (sum >= SW'(NUM_REQ)) begin
                sum = sum - SW'(NUM_REQ);
            end
            cand = sum[IDX_WIDTH-1:0];
            if (!grant_any && req_valid[cand]) begin
                grant_any   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/hash_table_arbiter.sv
// Round-robin front end sharing one hash_table among NUM_REQ requesters.
// Optional transaction/hit counters are enabled by defining HT_ARB_STATS_EN.
module hash_table_arbiter
    import hash_table_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int KEY_WIDTH     = 32,
    parameter int VALUE_WIDTH   = 64,
    parameter int REQ_IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [2*NUM_REQ-1:0]           req_op,
    input  logic [KEY_WIDTH*NUM_REQ-1:0]   req_key,
    input  logic [VALUE_WIDTH*NUM_REQ-1:0] req_value,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic                           rsp_success,
    output logic [VALUE_WIDTH-1:0]         rsp_value,
    output logic [1:0]                     ht_op,
    output logic [KEY_WIDTH-1:0]           ht_key,
    output logic [VALUE_WIDTH-1:0]         ht_value_in,
    input  logic [VALUE_WIDTH-1:0]         ht_value_out,
    input  logic                           ht_success,
    input  logic [1:0]                     ht_state
`ifdef HT_ARB_STATS_EN
    ,
    input  logic                           stat_clr,
    output logic [31:0]                    stat_ops,
    output logic [31:0]                    stat_hits
`endif
);

    arb_state_t state, state_nxt;

    logic [REQ_IDX_WIDTH-1:0] rr_ptr;
    logic [REQ_IDX_WIDTH-1:0] win_idx;
    logic [NUM_REQ-1:0]       win_grant;
    logic                     win_any;
    logic [1:0]               win_op;
    logic [KEY_WIDTH-1:0]     win_key;
    logic [VALUE_WIDTH-1:0]   win_value;

    logic [NUM_REQ-1:0]       lat_grant;
    logic [1:0]               lat_op;
    logic [KEY_WIDTH-1:0]     lat_key;
    logic [VALUE_WIDTH-1:0]   lat_value;
    logic                     cap_success;
    logic [VALUE_WIDTH-1:0]   cap_value;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (REQ_IDX_WIDTH)
    ) u_rr (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (win_grant),
        .grant_idx (win_idx),
        .grant_any (win_any)
    );

    always_comb begin
        win_op    = OP_NOOP;
        win_key   = '0;
        win_value = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_grant[i]) begin
                win_op    = req_op[2*i +: 2];
                win_key   = req_key[KEY_WIDTH*i +: KEY_WIDTH];
                win_value = req_value[VALUE_WIDTH*i +: VALUE_WIDTH];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     if (win_any) state_nxt = (win_op == OP_NOOP) ? RESP : ISSUE;
            ISSUE:   if (ht_state == HT_IDLE) state_nxt = WAIT;
            WAIT:    if (ht_state == HT_DONE) state_nxt = RESP;
            RESP:    state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    // The table only sees a real op while it is being issued or worked on.
    assign req_ready   = (state == ARB && !rst) ? win_grant : '0;
    assign ht_op       = (state == ISSUE || state == WAIT) ? lat_op : OP_NOOP;
    assign ht_key      = lat_key;
    assign ht_value_in = lat_value;
    assign rsp_valid   = (state == RESP) ? lat_grant : '0;
    assign rsp_success = (state == RESP) ? cap_success : 1'b0;
    assign rsp_value   = (state == RESP) ? cap_value : '0;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking throughout so every register samples pre-edge values.
        if (rst) begin
            state       <= ARB;
            rr_ptr      <= '0;
            lat_grant   <= '0;
            lat_op      <= OP_NOOP;
            lat_key     <= '0;
            lat_value   <= '0;
            cap_success <= 1'b0;
            cap_value   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB && win_any) begin
                lat_grant   <= win_grant;
                lat_op      <= win_op;
                lat_key     <= win_key;
                lat_value   <= win_value;
                cap_success <= 1'b0;
                cap_value   <= '0;
                rr_ptr      <= (win_idx == REQ_IDX_WIDTH'(NUM_REQ - 1)) ?
                               '0 : win_idx + REQ_IDX_WIDTH'(1);
            end
            if (state == WAIT && ht_state == HT_DONE) begin
                cap_success <= ht_success;
                cap_value   <= ht_value_out;
            end
        end
    end

`ifdef HT_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stat_ops  <= '0;
            stat_hits <= '0;
        end else if (state == RESP && lat_op != OP_NOOP) begin
            if (stat_ops != '1) stat_ops <= stat_ops + 32'd1;
            if (cap_success && stat_hits != '1) stat_hits <= stat_hits + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hash_table_arbiter.sv
// Randomized bench for hash_table_arbiter: emulates the table, predicts grants
// and responses from a map-based model, and checks via a response scoreboard.
module tb_hash_table_arbiter;

    localparam int N  = 4;
    localparam int KW = 32;
    localparam int VW = 64;

    localparam logic [1:0] NOOP = 2'd0, INSERT = 2'd1, LOOKUP = 2'd2, ERASE = 2'd3;
    localparam logic [1:0] T_IDLE = 2'd0, T_SEARCH = 2'd1, T_INSERT = 2'd2, T_DONE = 2'd3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid, req_ready, rsp_valid;
    logic [2*N-1:0]  req_op;
    logic [KW*N-1:0] req_key;
    logic [VW*N-1:0] req_value;
    logic            rsp_success;
    logic [VW-1:0]   rsp_value;
    logic [1:0]      ht_op, ht_state;
    logic [KW-1:0]   ht_key;
    logic [VW-1:0]   ht_value_in, ht_value_out;
    logic            ht_success;
    logic            stat_clr = 1'b0;
    logic [31:0]     stat_ops, stat_hits;

    logic            r_valid [N];
    logic [1:0]      r_op    [N];
    logic [KW-1:0]   r_key   [N];
    logic [VW-1:0]   r_value [N];
    bit              accepted[N];

    for (genvar g = 0; g < N; g++) begin : g_req
        assign req_valid[g]           = r_valid[g];
        assign req_op[2*g +: 2]       = r_op[g];
        assign req_key[KW*g +: KW]    = r_key[g];
        assign req_value[VW*g +: VW]  = r_value[g];
    end

    hash_table_arbiter #(.NUM_REQ(N), .KEY_WIDTH(KW), .VALUE_WIDTH(VW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_key      (req_key),
        .req_value    (req_value),
        .rsp_valid    (rsp_valid),
        .rsp_success  (rsp_success),
        .rsp_value    (rsp_value),
        .ht_op        (ht_op),
        .ht_key       (ht_key),
        .ht_value_in  (ht_value_in),
        .ht_value_out (ht_value_out),
        .ht_success   (ht_success),
        .ht_state     (ht_state)
`ifdef HT_ARB_STATS_EN
        ,
        .stat_clr     (stat_clr),
        .stat_ops     (stat_ops),
        .stat_hits    (stat_hits)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int b_ops   = 0;
    int b_hits  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [N-1:0]  id;
        logic [1:0]    op;
        logic [KW-1:0] key;
        logic [VW-1:0] value;
        logic          succ;
        logic [VW-1:0] val_exp;
    } exp_t;

    exp_t          sb[$];
    logic [VW-1:0] ref_mem [logic [KW-1:0]];
    logic [VW-1:0] emu_mem [logic [KW-1:0]];
    int            ref_rr = 0;

    // Table emulator: samples op while IDLE, random busy latency, one DONE cycle.
    initial begin
        logic          s_rst;
        logic [1:0]    s_op;
        logic [KW-1:0] s_key;
        logic [VW-1:0] s_val;
        logic          r_succ;
        logic [VW-1:0] r_val;
        int            busy;
        ht_state = T_IDLE; ht_success = 1'b0; ht_value_out = '0;
        r_succ = 1'b0; r_val = '0; busy = 0;
        forever begin
            @(negedge clk);
            s_rst = rst; s_op = ht_op; s_key = ht_key; s_val = ht_value_in;
            @(posedge clk); #1;
            if (s_rst) begin
                emu_mem.delete();
                ht_state = T_IDLE; ht_success = 1'b0; ht_value_out = '0;
            end else begin
                case (ht_state)
                    T_IDLE: if (s_op != NOOP) begin
                        r_succ = 1'b0; r_val = '0;
                        if (s_op == INSERT) begin
                            emu_mem[s_key] = s_val; r_succ = 1'b1; r_val = s_val;
                        end else if (emu_mem.exists(s_key)) begin
                            r_succ = 1'b1; r_val = emu_mem[s_key];
                            if (s_op == ERASE) emu_mem.delete(s_key);
                        end
                        ht_state = (s_op == INSERT) ? T_INSERT : T_SEARCH;
                        busy = $urandom_range(0, 3);
                    end else if ($urandom_range(0, 1) == 1) begin
                        ht_state = T_DONE; ht_success = 1'b0; ht_value_out = '0;
                    end
                    T_SEARCH, T_INSERT: if (busy == 0) begin
                        ht_state = T_DONE; ht_success = r_succ; ht_value_out = r_val;
                    end else begin
                        busy--;
                    end
                    default: begin
                        ht_state = T_IDLE; ht_success = 1'b0; ht_value_out = '0;
                    end
                endcase
            end
        end
    end

    // Grant tracker: predicts the round-robin winner and pushes the expected response.
    initial begin
        int           w;
        int           idx;
        bit           busy;
        logic [N-1:0] exp_r;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy = (sb.size() != 0);
                w = -1;
                for (int off = 0; off < N; off++) begin
                    idx = (ref_rr + off) % N;
                    if (w < 0 && req_valid[idx]) w = idx;
                end
                exp_r = (busy || w < 0) ? '0 : (N'(1) << w);
                check("req_ready", 64'(req_ready), 64'(exp_r));
                if (ht_op != NOOP) begin
                    if (!busy) begin
                        check("ht_op_idle", 64'(ht_op), 64'(NOOP));
                    end else begin
                        check("ht_op", 64'(ht_op), 64'(sb[0].op));
                        check("ht_key", 64'(ht_key), 64'(sb[0].key));
                        if (sb[0].op == INSERT) check("ht_value_in", ht_value_in, sb[0].value);
                    end
                end
                if (!busy && w >= 0) begin
                    e.id = N'(1) << w; e.op = r_op[w]; e.key = r_key[w]; e.value = r_value[w];
                    e.succ = 1'b0; e.val_exp = '0;
                    case (e.op)
                        INSERT: begin ref_mem[e.key] = e.value; e.succ = 1'b1; e.val_exp = e.value; end
                        LOOKUP, ERASE: if (ref_mem.exists(e.key)) begin
                            e.succ = 1'b1; e.val_exp = ref_mem[e.key];
                            if (e.op == ERASE) ref_mem.delete(e.key);
                        end
                        default: ;
                    endcase
                    sb.push_back(e);
                    accepted[w] = 1'b1;
                    ref_rr = (w + 1) % N;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a response strobe appears.
    initial begin
        int   waited = 0;
        exp_t e;
        forever begin
            @(negedge clk); #1;
            if (!rst) begin
                if (rsp_valid != '0) begin
                    if (sb.size() == 0) begin
                        check("rsp_unexpected", 64'(rsp_valid), 64'(0));
                    end else begin
                        e = sb.pop_front();
                        waited = 0;
                        check("rsp_valid", 64'(rsp_valid), 64'(e.id));
                        check("rsp_success", 64'(rsp_success), 64'(e.succ));
                        check("rsp_value", rsp_value, e.val_exp);
                        if (e.op != NOOP) begin
                            b_ops++;
                            if (e.succ) b_hits++;
                        end
                    end
                end else begin
                    check("rsp_idle", rsp_value | 64'(rsp_success), 64'(0));
                    if (sb.size() != 0) waited++;
                    if (waited > 200) begin
                        check("rsp_timeout", 64'(waited), 64'(0));
                        sb.delete();
                        waited = 0;
                    end
                end
            end else begin
                waited = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            if (accepted[i]) begin
                accepted[i] = 1'b0;
                r_valid[i]  = 1'b0;
            end
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [KW-1:0] k,
                           input logic [VW-1:0] v);
        r_op[i] = op; r_key[i] = k; r_value[i] = v; r_valid[i] = 1'b1;
    endtask

    task automatic drain(input string tag);
        int cyc = 0;
        while ((req_valid != '0 || sb.size() != 0) && cyc < 400) begin
            tick();
            cyc++;
        end
        check({tag, "_drain"}, 64'(cyc < 400), 64'(1));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        check({tag, "_rsp_success"}, 64'(rsp_success), 64'(0));
        check({tag, "_rsp_value"}, rsp_value, 64'(0));
        check({tag, "_ht_op"}, 64'(ht_op), 64'(NOOP));
        check({tag, "_ht_key"}, 64'(ht_key), 64'(0));
        check({tag, "_ht_value_in"}, ht_value_in, 64'(0));
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < N; i++) begin
            r_valid[i] = 1'b0; r_op[i] = NOOP; r_key[i] = '0; r_value[i] = '0; accepted[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_idle_outputs("reset");

        set_req(0, INSERT, 32'h10, 64'hAA);
        drain("insert");
        set_req(0, LOOKUP, 32'h10, 64'h0);
        drain("lookup");

        for (int i = 0; i < N; i++) set_req(i, LOOKUP, 32'h10, 64'h0);
        drain("all_four");
        repeat (2) begin
            set_req(1, LOOKUP, 32'h10, 64'h0);
            set_req(3, LOOKUP, 32'h11, 64'h0);
            drain("one_three");
        end

        set_req(0, ERASE, 32'h10, 64'h0);
        drain("erase");
        set_req(0, ERASE, 32'h10, 64'h0);
        drain("erase_again");
        set_req(0, LOOKUP, 32'h10, 64'h0);
        drain("lookup_erased");

        set_req(2, NOOP, 32'h55, 64'h66);
        drain("noop");

        // Abort an INSERT while the table is working on it.
        set_req(1, INSERT, 32'h30, 64'h1234);
        cyc = 0;
        while (ht_state != T_INSERT && cyc < 50) begin
            tick();
            cyc++;
        end
        check("reach_wait", 64'(cyc < 50), 64'(1));
        rst = 1'b1;
        sb.delete();
        ref_mem.delete();
        ref_rr = 0;
        tick();
        rst = 1'b0;
        check_idle_outputs("abort");
        repeat (5) tick();
        set_req(2, LOOKUP, 32'h30, 64'h0);
        drain("post_abort_lookup");
        set_req(2, INSERT, 32'h30, 64'h5678);
        drain("post_abort_insert");

        b_ops = 0;
        b_hits = 0;
        rst = 1'b1;
        ref_mem.delete();
        ref_rr = 0;
        tick();
        rst = 1'b0;

        repeat (800) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (!r_valid[i] && $urandom_range(0, 3) == 0) begin
                    set_req(i, 2'($urandom_range(0, 3)), 32'h10 + 32'($urandom_range(0, 5)),
                            {$urandom, $urandom});
                end
            end
        end
        drain("random");

`ifdef HT_ARB_STATS_EN
        check("stat_ops", 64'(stat_ops), 64'(b_ops));
        check("stat_hits", 64'(stat_hits), 64'(b_hits));
        set_req(0, INSERT, 32'h77, 64'h1);
        cyc = 0;
        while (rsp_valid == '0 && cyc < 100) begin
            tick();
            cyc++;
        end
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("stat_clr_ops", 64'(stat_ops), 64'(0));
        check("stat_clr_hits", 64'(stat_hits), 64'(0));
        drain("stats");
`endif

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
